// File: rtl/rtc_bus_mst.sv
// rtc_bus_mst: command-driven bus master for the ptpv2 RTC block (time reads, offset writes, clear).
// Optional macro RTC_MST_COHERENT_RD_EN: re-read the seconds word after a read and retry one pass on change.

`ifndef PTPV2_DEFINES_VH
`define PTPV2_DEFINES_VH
`define RTC_BLK_ADDR   24'h000A00
`define RTC_CTL_ADDR   8'h00
`define NS_OFST_ADDR   8'h08
`define SC_OFST_ADDR0  8'h0C
`define SC_OFST_ADDR1  8'h10
`define CUR_TM_ADDR0   8'h20
`define CUR_TM_ADDR1   8'h24
`define CUR_TM_ADDR2   8'h28
`define PTS_ADDR0      8'h30
`define PTS_ADDR1      8'h34
`define PTS_ADDR2      8'h38
`endif

module rtc_bus_mst (
    input  logic        bus2ip_clk,
    input  logic        bus2ip_rst_n,
    input  logic        cmd_valid_i,
    input  logic [1:0]  cmd_op_i,
    input  logic [31:0] cmd_ns_ofst_i,
    input  logic [47:0] cmd_sc_ofst_i,
    input  logic        intxms_sel_i,
    output logic        cmd_ready_o,
    output logic        rsp_valid_o,
    output logic [79:0] rsp_std_o,
    output logic [15:0] rsp_fns_o,
    output logic [31:0] bus2ip_addr_o,
    output logic [31:0] bus2ip_data_o,
    output logic        bus2ip_rd_ce_o,
    output logic        bus2ip_wr_ce_o,
    input  logic [31:0] ip2bus_data_i
);

    localparam int unsigned DW   = 32;
    localparam int unsigned SCW  = 48;
    localparam int unsigned STDW = 80;
    localparam int unsigned FNSW = 16;
    localparam int unsigned IW   = 2;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD   = 3'd1,
        ST_RWT  = 3'd2,
        ST_WR   = 3'd3,
        ST_GAP  = 3'd4,
        ST_DONE = 3'd5
    } state_e;

    state_e            state_q, state_d;
    logic [IW-1:0]     idx_q, idx_d;
    logic [1:0]        op_q, op_d;
    logic [DW-1:0]     ns_q, ns_d;
    logic [SCW-1:0]    sc_q, sc_d;
    logic              sel_q, sel_d;
    logic [DW-1:0]     w0_q, w0_d;
    logic [DW-1:0]     w1_q, w1_d;
`ifdef RTC_MST_COHERENT_RD_EN
    logic [DW-1:0]     w2_q, w2_d;
    logic              retry_q, retry_d;
`endif

    logic              ready_q, ready_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [STDW-1:0]   rsp_std_q, rsp_std_d;
    logic [FNSW-1:0]   rsp_fns_q, rsp_fns_d;
    logic [DW-1:0]     addr_q, addr_d;
    logic [DW-1:0]     data_q, data_d;
    logic              rd_ce_q, rd_ce_d;
    logic              wr_ce_q, wr_ce_d;

    logic              accept_c;
    logic [DW-1:0]     w2_c;

    assign accept_c = cmd_valid_i & ready_q;

    // Third word as seen on the transition into DONE: live bus data unless it came from the re-read.
`ifdef RTC_MST_COHERENT_RD_EN
    assign w2_c = (idx_q == 2'd2) ? ip2bus_data_i : w2_q;
`else
    assign w2_c = ip2bus_data_i;
`endif

    function automatic logic [7:0] rd_ofst(input logic pts, input logic [IW-1:0] idx);
        logic [7:0] o;
        case (idx)
            2'd1:    o = pts ? `PTS_ADDR1 : `CUR_TM_ADDR1;
            2'd2:    o = pts ? `PTS_ADDR2 : `CUR_TM_ADDR2;
            default: o = pts ? `PTS_ADDR0 : `CUR_TM_ADDR0;  // idx 3 re-reads w0
        endcase
        return o;
    endfunction

    // State and output registers.
    always_ff @(posedge bus2ip_clk) begin
        if (!bus2ip_rst_n) begin
            state_q     <= ST_IDLE;
            idx_q       <= '0;
            op_q        <= '0;
            ns_q        <= '0;
            sc_q        <= '0;
            sel_q       <= 1'b0;
            w0_q        <= '0;
            w1_q        <= '0;
`ifdef RTC_MST_COHERENT_RD_EN
            w2_q        <= '0;
            retry_q     <= 1'b0;
`endif
            ready_q     <= 1'b0;
            rsp_valid_q <= 1'b0;
            rsp_std_q   <= '0;
            rsp_fns_q   <= '0;
            addr_q      <= '0;
            data_q      <= '0;
            rd_ce_q     <= 1'b0;
            wr_ce_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            op_q        <= op_d;
            ns_q        <= ns_d;
            sc_q        <= sc_d;
            sel_q       <= sel_d;
            w0_q        <= w0_d;
            w1_q        <= w1_d;
`ifdef RTC_MST_COHERENT_RD_EN
            w2_q        <= w2_d;
            retry_q     <= retry_d;
`endif
            ready_q     <= ready_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_std_q   <= rsp_std_d;
            rsp_fns_q   <= rsp_fns_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            rd_ce_q     <= rd_ce_d;
            wr_ce_q     <= wr_ce_d;
        end
    end

    // Next-state, command latch, word capture and response update.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        ns_d      = ns_q;
        sc_d      = sc_q;
        sel_d     = sel_q;
        w0_d      = w0_q;
        w1_d      = w1_q;
`ifdef RTC_MST_COHERENT_RD_EN
        w2_d      = w2_q;
        retry_d   = retry_q;
`endif
        rsp_std_d = rsp_std_q;
        rsp_fns_d = rsp_fns_q;

        unique case (state_q)
            ST_IDLE: begin
                if (accept_c) begin
                    op_d  = cmd_op_i;
                    ns_d  = cmd_ns_ofst_i;
                    sc_d  = cmd_sc_ofst_i;
                    sel_d = intxms_sel_i;
                    idx_d = 2'd0;
                    if (!cmd_op_i[1]) begin
                        state_d = ST_RD;
                    end else begin
                        state_d = ST_WR;
                        // Clear skips straight to the control write.
                        if (cmd_op_i[0]) idx_d = 2'd3;
                    end
                end
            end
            ST_RD: state_d = ST_RWT;
            ST_RWT: begin
                state_d = ST_RD;
                idx_d   = idx_q + 2'd1;
                case (idx_q)
                    2'd0: w0_d = ip2bus_data_i;
                    2'd1: w1_d = ip2bus_data_i;
`ifdef RTC_MST_COHERENT_RD_EN
                    2'd2: begin
                        w2_d = ip2bus_data_i;
                        if (retry_q) state_d = ST_DONE;
                    end
                    default: begin
                        if (ip2bus_data_i == w0_q) begin
                            state_d = ST_DONE;
                        end else begin
                            retry_d = 1'b1;
                            idx_d   = 2'd0;
                        end
                    end
`else
                    default: state_d = ST_DONE;
`endif
                endcase
                if (state_d == ST_DONE) begin
                    rsp_std_d = {w0_q, w1_q, w2_c[31:16]};
                    rsp_fns_d = w2_c[15:0];
                end
            end
            ST_WR: begin
                if (idx_q == 2'd3) begin
                    state_d = ST_GAP;
                    idx_d   = 2'd0;
                end else begin
                    idx_d = idx_q + 2'd1;
                end
            end
            ST_GAP: begin
                if (idx_q == 2'd2) state_d = ST_DONE;
                else               idx_d   = idx_q + 2'd1;
            end
            ST_DONE: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
`ifdef RTC_MST_COHERENT_RD_EN
                retry_d = 1'b0;
`endif
            end
            default: begin
                state_d = ST_IDLE;
                idx_d   = 2'd0;
            end
        endcase
    end

    // Output register inputs, decoded from the state being entered.
    always_comb begin
        ready_d     = (state_d == ST_IDLE);
        rsp_valid_d = (state_d == ST_DONE);
        rd_ce_d     = (state_d == ST_RD);
        wr_ce_d     = (state_d == ST_WR);
        addr_d      = '0;
        data_d      = '0;
        if (rd_ce_d) begin
            addr_d = {`RTC_BLK_ADDR, rd_ofst(op_d[0], idx_d)};
        end else if (wr_ce_d) begin
            case (idx_d)
                2'd0: begin
                    addr_d = {`RTC_BLK_ADDR, `NS_OFST_ADDR};
                    data_d = ns_d;
                end
                2'd1: begin
                    addr_d = {`RTC_BLK_ADDR, `SC_OFST_ADDR0};
                    data_d = {16'h0, sc_d[47:32]};
                end
                2'd2: begin
                    addr_d = {`RTC_BLK_ADDR, `SC_OFST_ADDR1};
                    data_d = sc_d[31:0];
                end
                default: begin
                    addr_d = {`RTC_BLK_ADDR, `RTC_CTL_ADDR};
                    data_d = {29'h0, sel_d, op_d[0], ~op_d[0]};
                end
            endcase
        end
    end

    assign cmd_ready_o    = ready_q;
    assign rsp_valid_o    = rsp_valid_q;
    assign rsp_std_o      = rsp_std_q;
    assign rsp_fns_o      = rsp_fns_q;
    assign bus2ip_addr_o  = addr_q;
    assign bus2ip_data_o  = data_q;
    assign bus2ip_rd_ce_o = rd_ce_q;
    assign bus2ip_wr_ce_o = wr_ce_q;

endmodule
